// File: rtl/lc3b_mem_bridge_if.sv
// CPU-side and physical-memory-side bus bundle for the LC-3b memory bridge.
interface lc3b_mem_bridge_if;
    // CPU port
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    // Physical memory port
    logic        pmem_req;
    logic        pmem_we;
    logic [15:0] pmem_addr;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_be;
    logic        pmem_ready;
    logic [15:0] pmem_rdata;

    // Environment view: drives CPU requests and memory responses
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be,
        output pmem_ready, pmem_rdata
    );

    // Bridge view
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be,
        input  pmem_ready, pmem_rdata
    );
endinterface

// File: rtl/lc3b_mem_bridge.sv
// Bridges the LC-3b level-held memory request to a registered req/ready
// handshake on a variable-latency memory, with a hung-memory timeout.
module lc3b_mem_bridge #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic                clk,
    input  logic                reset,
    lc3b_mem_bridge_if.slave    bus,
    output logic                bus_err,
    output logic [7:0]          timeout_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Access sequencer: latches the request, runs the handshake, reports completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.mem_resp    <= 1'b0;
            bus.mem_rdata   <= '0;
            bus.pmem_req    <= 1'b0;
            bus.pmem_we     <= 1'b0;
            bus.pmem_addr   <= '0;
            bus.pmem_wdata  <= '0;
            bus.pmem_be     <= '0;
            bus_err         <= 1'b0;
            timeout_cnt     <= '0;
        end else begin
            bus.mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        // Read+write conflict resolves as a write and flags an error
                        bus.pmem_we    <= bus.mem_write;
                        bus.pmem_be    <= bus.mem_write ? bus.mem_byte_enable : 2'b11;
                        bus.pmem_addr  <= bus.mem_address & 16'hFFFE;
                        bus.pmem_wdata <= bus.mem_wdata;
                        bus.pmem_req   <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= REQ;
                        if (bus.mem_read && bus.mem_write) begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Ready in the final wait cycle still counts as a normal completion
                    if (bus.pmem_ready) begin
                        if (!bus.pmem_we) begin
                            bus.mem_rdata <= bus.pmem_rdata;
                        end
                        bus.pmem_req <= 1'b0;
                        bus.mem_resp <= 1'b1;
                        state        <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus_err <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        if (!bus.pmem_we) begin
                            bus.mem_rdata <= ERR_DATA;
                        end
                        bus.pmem_req <= 1'b0;
                        bus.mem_resp <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE: begin
                    // Always return to IDLE so a still-held request is not re-issued
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
